fir_out_requant: RTL and testbench

- Sits directly downstream of the FIR filter; consumes the full-precision filter output one sample per clock.
- Decimates by DECIM.
- Rounds and arithmetic-shifts each kept sample, then saturates it to WIDTH_O signed.
- Delivers results through a small FIFO with a valid/ready handshake. Samples that arrive while the FIFO is full are dropped and flagged.

---
 rtl/fir_pkg.sv | 42 ++++
 rtl/fir_sync_fifo.sv | 60 ++++++
 rtl/fir_out_requant.sv | 145 ++++++++++++++
 tb/tb_fir_out_requant.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output requantisation stages: a wide
// arithmetic type, the round/shift/saturate helper and FIFO sizing helper.
package fir_pkg;

  // Internal arithmetic width; wide enough that the rounding add never wraps.
  localparam int CALC_W = 64;
  typedef logic signed [CALC_W-1:0] calc_t;

  // Address width for a FIFO of the given depth (at least one bit).
  function automatic int fifo_addr_w(input int depth);
    return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
  endfunction

  // Round half up, then arithmetic right shift.
  function automatic calc_t round_shift(input calc_t value, input int shift);
    calc_t bias;
    if (shift > 32'sd0) begin
      bias = calc_t'(64'sd1) <<< (shift - 32'sd1);
    end else begin
      bias = calc_t'(64'sd0);
    end
    return (value + bias) >>> shift;
  endfunction

  // Round, shift and clip to the signed range of width_o bits.
  function automatic calc_t sat_round(input calc_t value, input int shift, input int width_o);
    calc_t r;
    calc_t max_v;
    calc_t min_v;
    r     = round_shift(value, shift);
    max_v = (calc_t'(64'sd1) <<< (width_o - 32'sd1)) - calc_t'(64'sd1);
    min_v = -(calc_t'(64'sd1) <<< (width_o - 32'sd1));
    if (r > max_v) begin
      return max_v;
    end else if (r < min_v) begin
      return min_v;
    end else begin
      return r;
    end
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Small synchronous FIFO with a registered memory and occupancy count.
// A push while full only succeeds when a pop happens in the same cycle;
// a pop while empty is ignored.
module fir_sync_fifo
  import fir_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = fifo_addr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage, pointers (wrap naturally at power-of-2 depth) and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_out_requant.sv
// FIR output requantiser: decimate, round/shift, saturate, then queue the
// result in a small FIFO with a valid/ready handshake. Kept samples arriving
// while the FIFO is full are dropped and flagged by a sticky overflow bit.
// Optional macro FIR_REQUANT_STATS_EN adds sat_count/drop_count counters.
module fir_out_requant
  import fir_pkg::*;
#(
  parameter int WIDTH_I    = 20,
  parameter int WIDTH_O    = 8,
  parameter int SHIFT      = 8,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_valid,
  input  logic signed [WIDTH_I-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [WIDTH_O-1:0] out_data,
  output logic                      sat,
  output logic                      overflow,
`ifdef FIR_REQUANT_STATS_EN
  output logic [15:0]               sat_count,
  output logic [15:0]               drop_count,
`endif
  input  logic                      clr_overflow
);

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [PH_W-1:0]           phase;
  logic                      keep;
  calc_t                     in_ext;
  calc_t                     rounded;
  calc_t                     clipped;
  logic                      clip;
  logic signed [WIDTH_O-1:0] requant;
  logic                      stage_v;
  logic [WIDTH_O-1:0]        stage_data;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [WIDTH_O-1:0]        fifo_dout;
  logic                      pop;
  logic                      drop;

  assign keep = in_valid & (phase == '0);

  // Decimation phase: advances only on valid input, wraps at DECIM-1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase <= '0;
    end else if (in_valid) begin
      if (phase == PH_W'(DECIM - 1)) begin
        phase <= '0;
      end else begin
        phase <= phase + PH_W'(1);
      end
    end else begin
      phase <= phase;
    end
  end

  // Round, shift and clip the incoming sample; clip flags any saturation.
  always_comb begin
    in_ext  = calc_t'(in_data);
    rounded = round_shift(in_ext, SHIFT);
    clipped = sat_round(in_ext, SHIFT, WIDTH_O);
    clip    = (rounded != clipped);
    requant = WIDTH_O'(clipped);
  end

  // Stage register: holds a kept sample for one cycle alongside its sat flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage_v    <= 1'b0;
      stage_data <= '0;
      sat        <= 1'b0;
    end else begin
      stage_v <= keep;
      sat     <= keep & clip;
      if (keep) begin
        stage_data <= requant;
      end
    end
  end

  fir_sync_fifo #(
    .WIDTH (WIDTH_O),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (stage_v),
    .din   (stage_data),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_dout;
  assign pop       = out_valid & out_ready;
  assign drop      = stage_v & fifo_full & ~pop;

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end else begin
      overflow <= overflow;
    end
  end

`ifdef FIR_REQUANT_STATS_EN
  // Saturating event counters; an increment takes priority over a clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sat_count  <= 16'd0;
      drop_count <= 16'd0;
    end else begin
      if (sat) begin
        if (sat_count != 16'hFFFF) begin
          sat_count <= sat_count + 16'd1;
        end
      end else if (clr_overflow) begin
        sat_count <= 16'd0;
      end
      if (drop) begin
        if (drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 16'd1;
        end
      end else if (clr_overflow) begin
        drop_count <= 16'd0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: one instance with DECIM=1 and one with
// DECIM=4, both with default widths, shift and FIFO depth.
module tb_fir_out_requant;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  logic              in_valid1 = 1'b0;
  logic signed [19:0] in_data1 = '0;
  logic              out_valid1;
  logic              out_ready1 = 1'b1;
  logic signed [7:0] out_data1;
  logic              sat1;
  logic              overflow1;
  logic              clr_overflow1 = 1'b0;

  logic              in_valid4 = 1'b0;
  logic signed [19:0] in_data4 = '0;
  logic              out_valid4;
  logic              out_ready4 = 1'b1;
  logic signed [7:0] out_data4;
  logic              sat4;
  logic              overflow4;
  logic              clr_overflow4 = 1'b0;

  int n_pass = 0;
  int n_total = 0;
  int idx4 = 0;
  int exp4 [6] = '{0, 4, 8, 0, 4, 8};

  always #5 clk = ~clk;

  fir_out_requant #(.WIDTH_I(20), .WIDTH_O(8), .SHIFT(8), .DECIM(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .sat(sat1), .overflow(overflow1), .clr_overflow(clr_overflow1)
  );

  fir_out_requant #(.WIDTH_I(20), .WIDTH_O(8), .SHIFT(8), .DECIM(4), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .sat(sat4), .overflow(overflow4), .clr_overflow(clr_overflow4)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One DECIM=1 sample through an empty FIFO with out_ready=1.
  task automatic send_one(input int data, input int exp, input int exp_sat);
    in_valid1 = 1'b1;
    in_data1  = 20'(data);
    step();
    in_valid1 = 1'b0;
    check("lat_sat", sat1, exp_sat);
    check("lat_novalid", out_valid1, 0);
    step();
    check("lat_valid", out_valid1, 1);
    check("lat_data", out_data1, exp);
    check("lat_sat_clear", sat1, 0);
    step();
    check("popped", out_valid1, 0);
  endtask

  // One DECIM=4 cycle; any output shown is compared with the expected list.
  task automatic drive4(input logic v, input int data);
    in_valid4 = v;
    in_data4  = 20'(data);
    step();
    if (out_valid4) begin
      if (idx4 < 6) check("decim_data", out_data4, exp4[idx4]);
      idx4++;
    end
  endtask

  initial begin
    step();
    step();
    check("rst_valid", out_valid1, 0);
    check("rst_data", out_data1, 0);
    check("rst_sat", sat1, 0);
    check("rst_ovf", overflow1, 0);
    rstn = 1'b1;
    step();

    // Rounding and saturation, DECIM=1
    send_one(384, 2, 0);
    send_one(-384, -1, 0);
    send_one(524287, 127, 1);
    send_one(-524288, -128, 1);
    send_one(32639, 127, 0);
    send_one(32640, 127, 1);

    // Decimation by 4, continuous then with a 3-cycle gap
    for (int k = 0; k < 12; k++) drive4(1'b1, 256 * k);
    for (int k = 0; k < 12; k++) begin
      if (k == 6) begin
        for (int g = 0; g < 3; g++) drive4(1'b0, 0);
      end
      drive4(1'b1, 256 * k);
    end
    for (int g = 0; g < 4; g++) drive4(1'b0, 0);
    check("decim_count", idx4, 6);

    // Fill with out_ready low: 4 queued, 2 dropped
    out_ready1 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      in_valid1 = 1'b1;
      in_data1  = 20'(256 * i);
      step();
    end
    in_valid1 = 1'b0;
    step();
    step();
    check("ovf_set", overflow1, 1);
    check("full_head_stable", out_data1, 1);
    out_ready1 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_valid", out_valid1, 1);
      check("drain_data", out_data1, i);
      step();
    end
    check("drain_empty", out_valid1, 0);
    out_ready1 = 1'b0;
    clr_overflow1 = 1'b1;
    step();
    clr_overflow1 = 1'b0;
    check("ovf_clr", overflow1, 0);

    // Full FIFO: push with simultaneous pop, then drop with clear
    for (int i = 10; i <= 14; i++) begin
      in_valid1 = 1'b1;
      in_data1  = 20'(256 * i);
      step();
    end
    in_valid1  = 1'b0;
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    check("pushpop_ovf", overflow1, 0);
    check("pushpop_head", out_data1, 11);
    in_valid1 = 1'b1;
    in_data1  = 20'(256 * 15);
    step();
    in_valid1 = 1'b0;
    clr_overflow1 = 1'b1;
    step();
    clr_overflow1 = 1'b0;
    check("set_wins", overflow1, 1);
    out_ready1 = 1'b1;
    for (int i = 11; i <= 14; i++) begin
      check("drain2_data", out_data1, i);
      step();
    end
    check("drain2_empty", out_valid1, 0);

    // Async reset with entries queued and DECIM=4 phase mid-count
    out_ready1 = 1'b0;
    out_ready4 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid1 = 1'b1;
      in_data1  = 20'(256 * i);
      in_valid4 = (i <= 2);
      in_data4  = 20'(256);
      step();
    end
    in_valid1 = 1'b0;
    in_valid4 = 1'b0;
    step();
    step();
    check("pre_rst_valid", out_valid1, 1);
    check("pre_rst_ovf", overflow1, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("async_valid", out_valid1, 0);
    check("async_data", out_data1, 0);
    check("async_ovf", overflow1, 0);
    check("async_valid4", out_valid4, 0);
    step();
    rstn = 1'b1;
    out_ready1 = 1'b1;
    in_valid1 = 1'b1;
    in_data1  = 20'(256 * 5);
    in_valid4 = 1'b1;
    in_data4  = 20'(256 * 7);
    step();
    in_valid1 = 1'b0;
    in_valid4 = 1'b0;
    step();
    check("post_rst_valid1", out_valid1, 1);
    check("post_rst_data1", out_data1, 5);
    check("post_rst_valid4", out_valid4, 1);
    check("post_rst_data4", out_data4, 7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
